// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
//   Shared MIPS32 decode constants for the ID stage:
//     - opcode / funct field values of the supported instruction subset
//     - ALU operation encodings
//     - bit positions of the 8-bit control word carried in ID/EX
//     - the control-word and ID/EX pipeline-register typedefs
//     - a 16->32 sign-extension helper
// ---------------------------------------------------------------------------
package mips_pkg;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes (instr[5:0])
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // ALU operations understood by EX
  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4
  } alu_op_e;

  // Bit positions inside idex_ctrl
  localparam int CTRL_REG_WRITE  = 7;
  localparam int CTRL_MEM_READ   = 6;
  localparam int CTRL_MEM_WRITE  = 5;
  localparam int CTRL_MEM_TO_REG = 4;
  localparam int CTRL_ALU_SRC    = 3;
  localparam int CTRL_ALU_OP_MSB = 2;
  localparam int CTRL_ALU_OP_LSB = 0;

  // 8-bit control word; field order matches the bit positions above
  typedef struct packed {
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    mem_to_reg;
    logic    alu_src;
    alu_op_e alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '0;

  // ID/EX pipeline register contents; all-zero is a bubble
  typedef struct packed {
    logic        valid;
    ctrl_t       ctrl;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] pc4;
  } idex_t;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/id_regfile.sv
// ---------------------------------------------------------------------------
// id_regfile
//   32 x 32-bit general register file, two combinational read ports and one
//   write port clocked on the rising edge. r0 always reads 0 and ignores
//   writes. Asynchronous active-high reset clears every register.
//
//   Optional feature macro: RF_BYPASS_EN
//     defined   : a write in progress to a non-zero address is forwarded to
//                 any read port addressing the same register (same cycle).
//     undefined : reads return the value held before this cycle's write.
//
// Ports
//   clk_i, rst_i           clock, async active-high reset
//   raddr_a_i / rdata_a_o  read port A (rs)
//   raddr_b_i / rdata_b_o  read port B (rt)
//   we_i, waddr_i, wdata_i write port (from WB)
// ---------------------------------------------------------------------------
module id_regfile
  import mips_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  raddr_a_i,
  input  logic [4:0]  raddr_b_i,
  output logic [31:0] rdata_a_o,
  output logic [31:0] rdata_b_o,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i
);

  logic [31:0] regs_q [32];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != 5'd0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  function automatic logic [31:0] read_port(input logic [4:0] addr);
    logic [31:0] val;
    if (addr == 5'd0) begin
      val = '0;
`ifdef RF_BYPASS_EN
    end else if (we_i && (waddr_i == addr)) begin
      val = wdata_i;
`endif
    end else begin
      val = regs_q[addr];
    end
    return val;
  endfunction

  always_comb begin
    rdata_a_o = read_port(raddr_a_i);
    rdata_b_o = read_port(raddr_b_i);
  end

endmodule

// File: rtl/id_stage.sv
// ---------------------------------------------------------------------------
// id_stage
//   Instruction-decode stage of a five-stage MIPS32 pipeline. Reads the
//   register file, decodes the IF/ID instruction, detects load-use,
//   branch-operand and (without RF_BYPASS_EN) WB read-after-write hazards,
//   resolves beq/bne/j, and owns the ID/EX pipeline register.
//
//   Optional feature macro: RF_BYPASS_EN (register-file write bypass; when
//   defined the WB hazard disappears because reads see the WB data).
//
// Ports
//   clk, rst                 clock, async active-high reset
//   if_valid/if_instr/if_pc4 IF/ID register contents
//   mem_we, mem_waddr        register write pending in MEM
//   wb_we/wb_waddr/wb_wdata  register-file write from WB
//   stall                    hold PC and IF/ID this cycle
//   redirect_valid/_pc       taken branch/jump target for IF
//   illegal                  one-cycle pulse for an undecodable instruction
//   idex_*                   ID/EX pipeline register outputs
//
// Handshake: IF presents an instruction with if_valid=1. It is consumed at
// the next rising edge unless stall=1 in this cycle, in which case IF must
// present the same instruction again. There is no ready from EX; ID/EX
// advances every cycle and receives a bubble whenever nothing is consumed.
// ---------------------------------------------------------------------------
module id_stage
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        if_valid,
  input  logic [31:0] if_instr,
  input  logic [31:0] if_pc4,
  input  logic        mem_we,
  input  logic [4:0]  mem_waddr,
  input  logic        wb_we,
  input  logic [4:0]  wb_waddr,
  input  logic [31:0] wb_wdata,
  output logic        stall,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        illegal,
  output logic        idex_valid,
  output logic [7:0]  idex_ctrl,
  output logic [31:0] idex_rs_data,
  output logic [31:0] idex_rt_data,
  output logic [31:0] idex_imm,
  output logic [4:0]  idex_rs,
  output logic [4:0]  idex_rt,
  output logic [4:0]  idex_rd,
  output logic [31:0] idex_pc4
);

  // Instruction fields
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rs_a;
  logic [4:0]  rt_a;
  logic [4:0]  rd_a;
  logic [15:0] imm16;

  assign opcode = if_instr[31:26];
  assign funct  = if_instr[5:0];
  assign rs_a   = if_instr[25:21];
  assign rt_a   = if_instr[20:16];
  assign rd_a   = if_instr[15:11];
  assign imm16  = if_instr[15:0];

  // Register file
  logic [31:0] rs_data;
  logic [31:0] rt_data;

  id_regfile u_regfile (
    .clk_i     (clk),
    .rst_i     (rst),
    .raddr_a_i (rs_a),
    .raddr_b_i (rt_a),
    .rdata_a_o (rs_data),
    .rdata_b_o (rt_data),
    .we_i      (wb_we),
    .waddr_i   (wb_waddr),
    .wdata_i   (wb_wdata)
  );

  // -------------------------------------------------------------------------
  // Decode
  // -------------------------------------------------------------------------
  ctrl_t       dec_ctrl;
  logic        dec_legal;
  logic [4:0]  dec_dest;
  logic [31:0] dec_imm;
  logic        use_rs;
  logic        use_rt;
  logic        is_beq;
  logic        is_bne;
  logic        is_j;

  always_comb begin
    dec_ctrl  = CTRL_NONE;
    dec_legal = 1'b1;
    dec_dest  = 5'd0;
    dec_imm   = sext16(imm16);
    use_rs    = (opcode != OP_J);
    use_rt    = 1'b0;
    is_beq    = 1'b0;
    is_bne    = 1'b0;
    is_j      = 1'b0;

    case (opcode)
      OP_RTYPE: begin
        use_rt = 1'b1;
        case (funct)
          FN_ADD:  dec_ctrl.alu_op = ALU_ADD;
          FN_SUB:  dec_ctrl.alu_op = ALU_SUB;
          FN_AND:  dec_ctrl.alu_op = ALU_AND;
          FN_OR:   dec_ctrl.alu_op = ALU_OR;
          FN_SLT:  dec_ctrl.alu_op = ALU_SLT;
          default: dec_legal = 1'b0;
        endcase
        if (dec_legal) begin
          dec_ctrl.reg_write = 1'b1;
          dec_dest           = rd_a;
        end
      end
      OP_ADDI: begin
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.alu_src   = 1'b1;
        dec_ctrl.alu_op    = ALU_ADD;
        dec_dest           = rt_a;
      end
      OP_ANDI: begin
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.alu_src   = 1'b1;
        dec_ctrl.alu_op    = ALU_AND;
        dec_dest           = rt_a;
        dec_imm            = {16'h0000, imm16};
      end
      OP_ORI: begin
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.alu_src   = 1'b1;
        dec_ctrl.alu_op    = ALU_OR;
        dec_dest           = rt_a;
        dec_imm            = {16'h0000, imm16};
      end
      OP_LW: begin
        // Address = rs + offset, so the immediate feeds the ALU.
        dec_ctrl.reg_write  = 1'b1;
        dec_ctrl.mem_read   = 1'b1;
        dec_ctrl.mem_to_reg = 1'b1;
        dec_ctrl.alu_src    = 1'b1;
        dec_ctrl.alu_op     = ALU_ADD;
        dec_dest            = rt_a;
      end
      OP_SW: begin
        dec_ctrl.mem_write = 1'b1;
        dec_ctrl.alu_src   = 1'b1;
        dec_ctrl.alu_op    = ALU_ADD;
        use_rt             = 1'b1;
      end
      OP_BEQ: begin
        is_beq = 1'b1;
        use_rt = 1'b1;
      end
      OP_BNE: begin
        is_bne = 1'b1;
        use_rt = 1'b1;
      end
      OP_J: begin
        is_j = 1'b1;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  // -------------------------------------------------------------------------
  // Hazard detection
  // -------------------------------------------------------------------------
  idex_t idex_q;
  idex_t idex_d;

  function automatic logic src_match(input logic [4:0] src, input logic used,
                                     input logic [4:0] dst);
    return used && (src != 5'd0) && (src == dst);
  endfunction

  logic any_match_ex;
  logic any_match_mem;
  logic load_use_hz;
  logic branch_hz;
  logic wb_hz;
  logic stall_raw;

  always_comb begin
    any_match_ex  = src_match(rs_a, use_rs, idex_q.rd) ||
                    src_match(rt_a, use_rt, idex_q.rd);
    any_match_mem = src_match(rs_a, use_rs, mem_waddr) ||
                    src_match(rt_a, use_rt, mem_waddr);

    load_use_hz = idex_q.valid && idex_q.ctrl.mem_read && any_match_ex;

    // Branches compare in ID, so any producer still in EX or MEM blocks them.
    branch_hz = (is_beq || is_bne) &&
                ((idex_q.ctrl.reg_write && any_match_ex) ||
                 (mem_we && any_match_mem));

`ifdef RF_BYPASS_EN
    wb_hz = 1'b0;
`else
    wb_hz = wb_we && (src_match(rs_a, use_rs, wb_waddr) ||
                      src_match(rt_a, use_rt, wb_waddr));
`endif

    stall_raw = if_valid && (load_use_hz || branch_hz || wb_hz);
  end

  // -------------------------------------------------------------------------
  // Branch / jump resolution
  // -------------------------------------------------------------------------
  logic        taken;
  logic [31:0] target;
  logic        issue;

  assign issue = if_valid && !stall_raw;

  always_comb begin
    taken  = is_j || (is_beq && (rs_data == rt_data)) ||
                     (is_bne && (rs_data != rt_data));
    if (is_j) begin
      target = {if_pc4[31:28], if_instr[25:0], 2'b00};
    end else begin
      target = if_pc4 + {dec_imm[29:0], 2'b00};
    end
  end

  // Reset forces the control outputs low even though they are combinational.
  assign stall          = !rst && stall_raw;
  assign redirect_valid = !rst && issue && taken;
  assign redirect_pc    = redirect_valid ? target : 32'h0;
  assign illegal        = !rst && issue && !dec_legal;

  // -------------------------------------------------------------------------
  // ID/EX pipeline register
  // -------------------------------------------------------------------------
  always_comb begin
    idex_d = '0;
    if (issue) begin
      // Branches, jumps and illegal instructions carry ctrl=0 from decode.
      idex_d.valid   = 1'b1;
      idex_d.ctrl    = dec_ctrl;
      idex_d.rs_data = rs_data;
      idex_d.rt_data = rt_data;
      idex_d.imm     = dec_imm;
      idex_d.rs      = rs_a;
      idex_d.rt      = rt_a;
      idex_d.rd      = dec_dest;
      idex_d.pc4     = if_pc4;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idex_q <= '0;
    end else begin
      idex_q <= idex_d;
    end
  end

  assign idex_valid   = idex_q.valid;
  assign idex_ctrl    = idex_q.ctrl;
  assign idex_rs_data = idex_q.rs_data;
  assign idex_rt_data = idex_q.rt_data;
  assign idex_imm     = idex_q.imm;
  assign idex_rs      = idex_q.rs;
  assign idex_rt      = idex_q.rt;
  assign idex_rd      = idex_q.rd;
  assign idex_pc4     = idex_q.pc4;

endmodule
